// File: rtl/med_rank_filter_pkg.sv
// Shared types and elaboration helpers for the rank-order filter.
package med_rank_filter_pkg;

    // Sequencer states: collect a window, run the serial sort passes,
    // present the result, or forward a bypass pixel.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SORT = 3'd2,
        ST_DONE = 3'd3,
        ST_PASS = 3'd4
    } state_e;

    // Legal window sizes: odd, between these bounds inclusive.
    localparam int NUMBER_MIN = 32'sd3;
    localparam int NUMBER_MAX = 32'sd25;

    // True when n is an acceptable window size.
    function automatic bit number_ok(input int n);
        return (n >= NUMBER_MIN) && (n <= NUMBER_MAX) && (n[0] == 1'b1);
    endfunction

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        if (n > 32'sd1) begin
            return $clog2(n);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/med_rank_filter_mce.sv
// Unsigned compare-exchange cell: routes the larger operand to max_o and the
// smaller to min_o. On a tie the operands pass straight through, so equal
// values are never reordered.
module med_rank_filter_mce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o
);

    // Single unsigned magnitude comparison, exchange only when b is strictly larger.
    always_comb begin
        max_o = a_i;
        min_o = b_i;
        if (a_i < b_i) begin
            max_o = b_i;
            min_o = a_i;
        end else begin
            max_o = a_i;
            min_o = b_i;
        end
    end

endmodule

// File: rtl/med_rank_filter.sv
// Rank-order filter: collects a NUMBER-sample window into a ring, then runs
// SEL+1 serial passes through one compare-exchange cell. Each pass sweeps the
// whole ring once, carrying the running maximum in an accumulator and pushing
// the smaller value back into the ring, so a pass retires the largest value
// still present and leaves a zero in its slot. The value retired by the
// last pass is the SEL-th largest sample. Bypass mode forwards pixels directly.
module med_rank_filter
    import med_rank_filter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUMBER = 9,
    parameter int SELW   = $clog2(NUMBER)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    input  logic [SELW-1:0]  SEL,
    input  logic             BYP,
    output logic             RDY,
    output logic [WIDTH-1:0] DO,
    output logic             DSO
);

    localparam int CNTW = cnt_width(NUMBER);

    localparam logic [CNTW-1:0]  CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(32'sd1);
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(NUMBER - 32'sd1);
    localparam logic [SELW-1:0]  SEL_ZERO = {SELW{1'b0}};
    localparam logic [SELW-1:0]  SEL_ONE  = SELW'(32'sd1);
    localparam logic [SELW-1:0]  SEL_LAST = SELW'(NUMBER - 32'sd1);
    localparam logic [WIDTH-1:0] PIX_ZERO = {WIDTH{1'b0}};

    // Refuse to elaborate with an unsupported window size or an overridden SELW.
    if (!number_ok(NUMBER)) begin : g_number_illegal
        $error("med_rank_filter: NUMBER must be odd and within 3..25");
    end
    if (SELW != $clog2(NUMBER)) begin : g_selw_illegal
        $error("med_rank_filter: SELW is derived from NUMBER and must not be overridden");
    end

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [SELW-1:0]  pass_q, pass_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ring_q [NUMBER];
    logic [WIDTH-1:0] ring_d [NUMBER];
    logic [WIDTH-1:0] do_q, do_d;
    logic             dso_q, dso_d;
    logic             rdy_q, rdy_d;

    logic             accept_s;
    logic [SELW-1:0]  sel_clamp_s;
    logic [WIDTH-1:0] cmp_a_s;
    logic [WIDTH-1:0] cmp_max_s;
    logic [WIDTH-1:0] cmp_min_s;
    logic [WIDTH-1:0] shift_in_s [NUMBER];
    logic [WIDTH-1:0] rotate_s   [NUMBER];

    // A sample is taken only when it is offered and the block advertised readiness.
    assign accept_s = DSI & rdy_q;

    // Out-of-range ranks collapse to the window minimum.
    always_comb begin
        sel_clamp_s = SEL;
        if (SEL > SEL_LAST) begin
            sel_clamp_s = SEL_LAST;
        end else begin
            sel_clamp_s = SEL;
        end
    end

    // Each pass starts its running maximum from zero, so the stale accumulator is masked on the first cycle.
    always_comb begin
        cmp_a_s = acc_q;
        if (cnt_q == CNT_ZERO) begin
            cmp_a_s = PIX_ZERO;
        end else begin
            cmp_a_s = acc_q;
        end
    end

    med_rank_filter_mce #(
        .WIDTH (WIDTH)
    ) u_mce (
        .a_i   (cmp_a_s),
        .b_i   (ring_q[0]),
        .max_o (cmp_max_s),
        .min_o (cmp_min_s)
    );

    // Ring movement: new samples enter at the tail while loading; during a pass the loser of each compare re-enters the tail.
    always_comb begin
        for (int i = 0; i < NUMBER - 1; i++) begin
            shift_in_s[i] = ring_q[i+1];
            rotate_s[i]   = ring_q[i+1];
        end
        shift_in_s[NUMBER-1] = DI;
        rotate_s[NUMBER-1]   = cmp_min_s;
    end

    // Sequencer next state plus datapath next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        ring_d  = ring_q;
        do_d    = do_q;
        dso_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_PASS: begin
                if (accept_s) begin
                    if (BYP) begin
                        do_d    = DI;
                        dso_d   = 1'b1;
                        state_d = ST_PASS;
                    end else begin
                        ring_d  = shift_in_s;
                        sel_d   = sel_clamp_s;
                        cnt_d   = CNT_ONE;
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    ring_d = shift_in_s;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        pass_d  = SEL_ZERO;
                        state_d = ST_SORT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SORT: begin
                acc_d  = cmp_max_s;
                ring_d = rotate_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (pass_q == sel_q) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_d = pass_q + SEL_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                do_d    = acc_q;
                dso_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Readiness is registered and follows the state being entered.
    always_comb begin
        rdy_d = 1'b0;
        case (state_d)
            ST_IDLE, ST_LOAD, ST_PASS: rdy_d = 1'b1;
            ST_SORT, ST_DONE:          rdy_d = 1'b0;
            default:                   rdy_d = 1'b0;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ring, counters, accumulator and registered outputs; reset drops any partial window.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= CNT_ZERO;
            pass_q <= SEL_ZERO;
            sel_q  <= SEL_ZERO;
            acc_q  <= PIX_ZERO;
            do_q   <= PIX_ZERO;
            dso_q  <= 1'b0;
            rdy_q  <= 1'b0;
            for (int i = 0; i < NUMBER; i++) begin
                ring_q[i] <= PIX_ZERO;
            end
        end else begin
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
            sel_q  <= sel_d;
            acc_q  <= acc_d;
            do_q   <= do_d;
            dso_q  <= dso_d;
            rdy_q  <= rdy_d;
            for (int i = 0; i < NUMBER; i++) begin
                ring_q[i] <= ring_d[i];
            end
        end
    end

    assign RDY = rdy_q;
    assign DO  = do_q;
    assign DSO = dso_q;

endmodule

// File: tb/tb_med_rank_filter.sv
// Directed and random bench for med_rank_filter with a result scoreboard.
module tb_med_rank_filter;

    localparam int WIDTH  = 8;
    localparam int NUMBER = 9;
    localparam int SELW   = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [SELW-1:0]  SEL;
    logic             BYP;
    logic             RDY;
    logic [WIDTH-1:0] DO;
    logic             DSO;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               cyc;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               last_acc = 0;
    logic [WIDTH-1:0] win [NUMBER];
    logic [WIDTH-1:0] byp_vals [3];

    med_rank_filter #(
        .WIDTH  (WIDTH),
        .NUMBER (NUMBER)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (DSI),
        .SEL  (SEL),
        .BYP  (BYP),
        .RDY  (RDY),
        .DO   (DO),
        .DSO  (DSO)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Rising-edge counter used to time results.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full descending sort of the current window, rank clamped to the minimum.
    function automatic logic [WIDTH-1:0] rank_model(input logic [SELW-1:0] sel);
        logic [WIDTH-1:0] s [NUMBER];
        logic [WIDTH-1:0] t;
        int               k;
        for (int i = 0; i < NUMBER; i++) s[i] = win[i];
        for (int i = 0; i < NUMBER; i++) begin
            for (int j = 0; j < NUMBER - 1 - i; j++) begin
                if (s[j] < s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        k = (int'(sel) > NUMBER - 1) ? NUMBER - 1 : int'(sel);
        return s[k];
    endfunction

    // Feed n samples of win; a complete window queues its expected result and DSO cycle.
    task automatic run_window(input logic [SELW-1:0] sel, input bit gaps, input int n);
        int   guard;
        int   selc;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                DSI = 1'b0;
                @(negedge CLK);
            end
            guard = 0;
            while (RDY !== 1'b1 && guard < 500) begin
                DSI = 1'b0;
                @(negedge CLK);
                guard++;
            end
            if (guard >= 500) check("rdy_wait", {31'd0, RDY}, 32'd1);
            DI  = win[i];
            DSI = 1'b1;
            if (i == 0) SEL = sel;
            @(negedge CLK);
        end
        DSI = 1'b0;
        last_acc = cyc;
        if (n == NUMBER) begin
            selc  = (int'(sel) > NUMBER - 1) ? NUMBER - 1 : int'(sel);
            e.val = rank_model(sel);
            e.cyc = last_acc + (selc + 1) * NUMBER + 1;
            sb_q.push_back(e);
        end
    endtask

    // Wait (bounded) until every queued result has been seen.
    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 400) begin
            @(negedge CLK);
            guard++;
        end
        check("drain", sb_q.size(), 32'd0);
        @(negedge CLK);
    endtask

    task automatic reset_checks();
        check("rst_rdy", {31'd0, RDY}, 32'd0);
        check("rst_do",  {24'd0, DO},  32'd0);
        check("rst_dso", {31'd0, DSO}, 32'd0);
    endtask

    // Scoreboard: every DSO must match the oldest expectation in value and cycle.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && DSO === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("dso_spurious", {31'd0, DSO}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("dso_data",  {24'd0, DO}, {24'd0, mon_e.val});
                check("dso_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Directed sequence followed by random windows.
    initial begin
        nRST = 1'b0; DI = 8'h00; DSI = 1'b0; SEL = 4'd0; BYP = 1'b0;
        repeat (2) @(negedge CLK);
        reset_checks();
        nRST = 1'b1;
        #1;
        check("rdy_before_edge", {31'd0, RDY}, 32'd0);
        @(negedge CLK);
        check("rdy_after_reset", {31'd0, RDY}, 32'd1);

        // Median, max, min and clamped rank of one window.
        win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4, 8'd5};
        run_window(4'd4, 1'b0, NUMBER);
        drain();
        check("do_hold_median", {24'd0, DO}, 32'd5);
        run_window(4'd0, 1'b0, NUMBER);
        drain();
        run_window(4'd8, 1'b0, NUMBER);
        drain();
        run_window(4'd15, 1'b0, NUMBER);
        drain();

        // Duplicates, and gapped versus gapless delivery.
        win = '{8'h80, 8'hFF, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h80, 8'h80};
        run_window(4'd4, 1'b0, NUMBER);
        drain();
        win = '{8'h05, 8'h00, 8'h08, 8'h03, 8'h01, 8'h07, 8'h02, 8'h06, 8'h04};
        run_window(4'd4, 1'b0, NUMBER);
        drain();
        run_window(4'd4, 1'b1, NUMBER);
        drain();

        // Bypass pixels on consecutive cycles.
        byp_vals = '{8'h11, 8'h22, 8'h33};
        BYP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("byp_rdy", {31'd0, RDY}, 32'd1);
            DI  = byp_vals[i];
            DSI = 1'b1;
            sb_q.push_back('{byp_vals[i], cyc + 1});
            @(negedge CLK);
        end
        DSI = 1'b0;
        BYP = 1'b0;
        drain();

        // Reset in the middle of loading.
        win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4, 8'd5};
        run_window(4'd4, 1'b0, 5);
        nRST = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("rdy_after_rst_load", {31'd0, RDY}, 32'd1);

        // Reset in the middle of sorting; the queued result is discarded.
        run_window(4'd4, 1'b0, NUMBER);
        repeat (20) @(negedge CLK);
        nRST = 1'b0;
        void'(sb_q.pop_back());
        #1;
        reset_checks();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (60) @(negedge CLK);
        check("do_after_rst_sort", {24'd0, DO}, 32'd0);
        run_window(4'd4, 1'b0, NUMBER);
        drain();

        // Offered samples and bypass requests during sorting must be ignored.
        run_window(4'd4, 1'b0, NUMBER);
        for (int i = 0; i < 20; i++) begin
            check("sort_rdy", {31'd0, RDY}, 32'd0);
            DSI = 1'b1;
            DI  = 8'($urandom_range(0, 255));
            BYP = (i % 2 == 1);
            @(negedge CLK);
        end
        DSI = 1'b0;
        BYP = 1'b0;
        drain();

        // Random windows with random ranks, back to back.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < NUMBER; j++) win[j] = 8'($urandom_range(0, 255));
            run_window(4'($urandom_range(0, 15)), (k % 2 == 1), NUMBER);
        end
        drain();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
